// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared CPU definitions: field widths, opcodes, controller states and
// the instruction encoding helpers used to build ROM images.
package cpu_pkg;

    localparam int OPC_W  = 2;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic [OPC_W-1:0] OP_HLT = 2'b00;
    localparam logic [OPC_W-1:0] OP_INC = 2'b01;
    localparam logic [OPC_W-1:0] OP_JMP = 2'b10;
    localparam logic [OPC_W-1:0] OP_ADD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [DATA_W-1:0] INSN_HLT = {OP_HLT, 6'd0};

    function automatic logic [DATA_W-1:0] insn(input logic [OPC_W-1:0] op,
                                               input logic [ADDR_W-1:0] addr);
        return {op, addr};
    endfunction

    function automatic logic [OPC_W-1:0] insn_op(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: OPC_W];
    endfunction

    function automatic logic [ADDR_W-1:0] insn_addr(input logic [DATA_W-1:0] word);
        return word[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// Program-ROM read bus: the CPU drives address and strobes, the ROM returns data.
interface rom_fetch_ctrl_if;

    logic [cpu_pkg::ADDR_W-1:0] rom_addr;
    logic                       rom_read;
    logic                       rom_ena;
    logic [cpu_pkg::DATA_W-1:0] rom_data;

    modport master (output rom_addr, output rom_read, output rom_ena, input rom_data);
    modport slave  (input rom_addr, input rom_read, input rom_ena, output rom_data);

endinterface

// File: rtl/rom_fetch_ctrl_rom_access_timer.sv
// Counts the strobe-high cycles of one ROM access; sample_now marks the
// final strobe cycle, on whose closing edge rom_data is captured.
module rom_access_timer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic sample_now
);

    logic [2:0] cnt;

    // Reload on access start, then count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= 3'(WAIT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - 3'd1;
    end

    assign sample_now = (cnt == '0);

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Fetch/execute controller of the accumulator CPU: fetches from the program
// ROM, decodes HLT/INC/JMP/ADD and updates accumulator and carry.
module rom_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned        WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC    = 6'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    rom_fetch_ctrl_if.master    bus,
    output logic [DATA_W-1:0]   accum,
    output logic                carry,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted
);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc_n;
    logic [DATA_W-1:0]   accum_n;
    logic                carry_n;
    logic [DATA_W-1:0]   ir, ir_n;
    logic [DATA_W-1:0]   opnd, opnd_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                strb_q, strb_n;
    logic                tmr_load;
    logic                sample_now;

    rom_access_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .sample_now (sample_now)
    );

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            accum  <= '0;
            carry  <= 1'b0;
            ir     <= '0;
            opnd   <= '0;
            addr_q <= '0;
            strb_q <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            accum  <= accum_n;
            carry  <= carry_n;
            ir     <= ir_n;
            opnd   <= opnd_n;
            addr_q <= addr_n;
            strb_q <= strb_n;
        end
    end

    // Next-state and next-datapath logic; strobes default low so every
    // access is separated by at least one idle strobe cycle.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        accum_n  = accum;
        carry_n  = carry;
        ir_n     = ir;
        opnd_n   = opnd;
        addr_n   = addr_q;
        strb_n   = 1'b0;
        tmr_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_FETCH;
                    addr_n   = pc;
                    strb_n   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            S_FETCH: begin
                if (sample_now) begin
                    ir_n    = bus.rom_data;
                    pc_n    = pc + 6'd1;
                    state_n = S_DECODE;
                end else begin
                    strb_n = 1'b1;
                end
            end
            S_DECODE: begin
                case (insn_op(ir))
                    OP_HLT: state_n = S_HALT;
                    OP_INC: begin
                        {carry_n, accum_n} = {1'b0, accum} + 9'd1;
                        state_n  = S_FETCH;
                        addr_n   = pc;
                        strb_n   = 1'b1;
                        tmr_load = 1'b1;
                    end
                    OP_JMP: begin
                        pc_n     = insn_addr(ir);
                        state_n  = S_FETCH;
                        addr_n   = insn_addr(ir);
                        strb_n   = 1'b1;
                        tmr_load = 1'b1;
                    end
                    default: begin
                        state_n  = S_OPND;
                        addr_n   = insn_addr(ir);
                        strb_n   = 1'b1;
                        tmr_load = 1'b1;
                    end
                endcase
            end
            S_OPND: begin
                if (sample_now) begin
                    opnd_n  = bus.rom_data;
                    state_n = S_EXEC;
                end else begin
                    strb_n = 1'b1;
                end
            end
            S_EXEC: begin
                {carry_n, accum_n} = {1'b0, accum} + {1'b0, opnd};
                state_n  = S_FETCH;
                addr_n   = pc;
                strb_n   = 1'b1;
                tmr_load = 1'b1;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.rom_addr = addr_q;
    assign bus.rom_read = strb_q;
    assign bus.rom_ena  = strb_q;
    assign busy         = (state != S_IDLE) && (state != S_HALT);
    assign halted       = (state == S_HALT);

endmodule
